// File: rtl/io_responder.sv
// io_responder: memory-mapped IO register window for a small core.
// Provides a one-entry UART rx buffer, a one-entry UART tx buffer,
// a free-running cycle counter and a retired-instruction counter.
// All reads return their data registered, one cycle after Io_recv.
module io_responder #(
   parameter logic [31:0] IO_BASE = 32'h8000_0000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] A,
   input  logic [3:0]  Io_trans,
   input  logic        Io_recv,
   input  logic [31:0] WriteData,
   input  logic        InstrRetire,
   output logic [31:0] ReadData,
   output logic [7:0]  TxData,
   output logic        TxValid,
   input  logic        TxReady,
   input  logic [7:0]  RxData,
   input  logic        RxValid,
   output logic        RxReady
);

   // Word offsets inside the window (A[7:2]).
   localparam logic [5:0] OFF_STATUS = 6'h00;
   localparam logic [5:0] OFF_RXDATA = 6'h01;
   localparam logic [5:0] OFF_TXDATA = 6'h02;
   localparam logic [5:0] OFF_CYCLE  = 6'h04;
   localparam logic [5:0] OFF_INSTR  = 6'h05;
   localparam logic [5:0] OFF_CLEAR  = 6'h06;

   logic [31:0] read_data_q, read_data_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_full_q, tx_full_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        rx_full_q, rx_full_d;
   logic [31:0] cyc_cnt_q, cyc_cnt_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;

   logic        in_window;
   logic [5:0]  off;
   logic        is_store;
   logic [31:0] read_mux;
   logic        rx_pop;
   logic        rx_capture;
   logic        tx_handshake;
   logic        tx_write;
   logic        cnt_clear;

   // Byte-select bits play no part in decode.
   logic        unused_a_low;
   assign unused_a_low = ^A[1:0];

   assign in_window = (A[31:8] == IO_BASE[31:8]);
   assign off       = A[7:2];
   assign is_store  = |Io_trans;

   // Readable register selection; write-only and unmapped offsets read as 0.
   always_comb begin
      read_mux = 32'h0;
      if (in_window) begin
         case (off)
            OFF_STATUS: read_mux = {30'b0, rx_full_q, ~tx_full_q};
            OFF_RXDATA: read_mux = {24'b0, rx_byte_q};
            OFF_CYCLE:  read_mux = cyc_cnt_q;
            OFF_INSTR:  read_mux = instr_cnt_q;
            default:    read_mux = 32'h0;
         endcase
      end
   end

   // Next-state logic for read port, buffers and counters.
   always_comb begin
      read_data_d = read_data_q;
      tx_data_d   = tx_data_q;
      tx_full_d   = tx_full_q;
      rx_byte_d   = rx_byte_q;
      rx_full_d   = rx_full_q;

      // Read: captures pre-edge state, holds until the next request.
      if (Io_recv) begin
         read_data_d = read_mux;
      end

      // Rx: reading the data register drains the entry; RxReady is low
      // while full, so a pop and a capture never land on the same edge.
      rx_pop     = Io_recv && in_window && (off == OFF_RXDATA) && rx_full_q;
      rx_capture = RxValid && !rx_full_q;
      if (rx_pop) begin
         rx_full_d = 1'b0;
      end else if (rx_capture) begin
         rx_full_d = 1'b1;
         rx_byte_d = RxData;
      end

      // Tx: a write is accepted if the slot is empty or draining this edge.
      tx_handshake = tx_full_q && TxReady;
      tx_write     = in_window && (off == OFF_TXDATA) && Io_trans[0];
      if (tx_write && (!tx_full_q || tx_handshake)) begin
         tx_full_d = 1'b1;
         tx_data_d = WriteData[7:0];
      end else if (tx_handshake) begin
         tx_full_d = 1'b0;
      end

      // Counters: clear wins over the increment of the same cycle.
      cnt_clear = in_window && (off == OFF_CLEAR) && is_store;
      if (cnt_clear) begin
         cyc_cnt_d   = 32'h0;
         instr_cnt_d = 32'h0;
      end else begin
         cyc_cnt_d   = cyc_cnt_q + 32'd1;
         instr_cnt_d = instr_cnt_q + {31'b0, InstrRetire};
      end
   end

   // State registers; reset abandons any buffered bytes.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         read_data_q <= 32'h0;
         tx_data_q   <= 8'h0;
         tx_full_q   <= 1'b0;
         rx_byte_q   <= 8'h0;
         rx_full_q   <= 1'b0;
         cyc_cnt_q   <= 32'h0;
         instr_cnt_q <= 32'h0;
      end else begin
         read_data_q <= read_data_d;
         tx_data_q   <= tx_data_d;
         tx_full_q   <= tx_full_d;
         rx_byte_q   <= rx_byte_d;
         rx_full_q   <= rx_full_d;
         cyc_cnt_q   <= cyc_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign ReadData = read_data_q;
   assign TxData   = tx_data_q;
   assign TxValid  = tx_full_q;
   assign RxReady  = ~rx_full_q;

endmodule
